// File: rtl/tiny_pkg.sv
// Shared definitions for the tiny processor: opcode map, sequencer state
// encoding and the datapath-opcode classifier.
package tiny_pkg;

    localparam logic [3:0] OP_BRC  = 4'h8;
    localparam logic [3:0] OP_RET  = 4'hB;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_SYS  = 4'hF;
    localparam logic [7:0] INSN_HLT = 8'hFF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_ISSUE  = 3'd3;
    localparam state_t ST_WAIT   = 3'd4;
    localparam state_t ST_HALT   = 3'd5;
    localparam state_t ST_ERR    = 3'd6;

    // Opcodes executed by the datapath rather than resolved by the sequencer.
    function automatic logic is_dp_op(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
            4'h9, 4'hA, 4'hE: is_dp_op = 1'b1;
            default:          is_dp_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tiny_ret_stack.sv
// Return-address LIFO for CALL/RET. Push and pop are ignored when they would
// overflow or underflow; the sequencer turns those cases into an error.
module tiny_ret_stack
    import tiny_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] push_data,
    output logic [7:0] top,
    output logic       full,
    output logic       empty
);

    // Storage is sized for the largest supported depth so the 3-bit index is exact.
    logic [7:0] mem_q [8];
    logic [3:0] cnt_q, cnt_d;

    assign full  = (cnt_q == 4'(STACK_DEPTH));
    assign empty = (cnt_q == 4'd0);
    assign top   = mem_q[3'(cnt_q - 4'd1)];

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 4'd0;
        end else if (push && !full) begin
            cnt_d = cnt_q + 4'd1;
        end else if (pop && !empty) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the entries carry no reset; the depth counter alone defines which are valid.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem_q[cnt_q[2:0]] <= push_data;
        end
    end

endmodule

// File: rtl/tiny_seq_ctrl.sv
// Instruction sequencer: owns the PC, resolves control flow locally and
// issues datapath instructions over a valid/ready/done handshake.
module tiny_seq_ctrl
    import tiny_pkg::*;
#(
    parameter int         STACK_DEPTH = 4,
    parameter logic [7:0] RESET_PC    = 8'h00
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic       op_valid,
    output logic [3:0] opcode,
    output logic [3:0] regaddr,
    input  logic       op_ready,
    input  logic       op_done,
    input  logic       carry_borrow,
    output logic [3:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic [7:0] pc,
    output logic       busy,
    output logic       halted,
    output logic       err
);

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] imem_addr_q, imem_addr_d;
    logic       op_valid_q, op_valid_d;
    logic [3:0] opcode_q, opcode_d;
    logic [3:0] regaddr_q, regaddr_d;
    logic       busy_q, busy_d;
    logic       halted_q, halted_d;
    logic       err_q, err_d;

    logic       stk_push, stk_pop, stk_clear;
    logic       stk_full, stk_empty;
    logic [7:0] stk_top;
    logic [7:0] insn;
    logic [7:0] pc_inc;

    // The synchronous memory presents the fetched word during DECODE; it is
    // decoded directly so control flow resolves in two cycles.
    assign insn   = imem_data;
    assign pc_inc = pc_q + 8'd1;

    tiny_ret_stack #(
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (stk_clear),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_data(pc_inc),
        .top      (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    assign rd_addr = (state_q == ST_DECODE) ? insn[3:0] : 4'h0;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        pc_d       = pc_q;
        op_valid_d = op_valid_q;
        opcode_d   = opcode_q;
        regaddr_d  = regaddr_q;
        err_d      = err_q;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_clear  = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT, ST_ERR: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = RESET_PC;
                    err_d     = 1'b0;
                    stk_clear = 1'b1;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                state_d = ST_FETCH;
                if (is_dp_op(insn[7:4])) begin
                    state_d    = ST_ISSUE;
                    op_valid_d = 1'b1;
                    opcode_d   = insn[7:4];
                    regaddr_d  = insn[3:0];
                end else begin
                    case (insn[7:4])
                        OP_BRC:  pc_d = carry_borrow ? rd_data : pc_inc;
                        OP_RET: begin
                            if (stk_empty) begin
                                state_d = ST_ERR;
                                err_d   = 1'b1;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = stk_top;
                            end
                        end
                        OP_CALL: begin
                            if (stk_full) begin
                                state_d = ST_ERR;
                                err_d   = 1'b1;
                            end else begin
                                stk_push = 1'b1;
                                pc_d     = rd_data;
                            end
                        end
                        OP_JMP:  pc_d = rd_data;
                        default: begin
                            // Only OP_SYS remains: HLT or NOP.
                            if (insn == INSN_HLT) begin
                                state_d = ST_HALT;
                            end else begin
                                pc_d = pc_inc;
                            end
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    if (op_done) begin
                        state_d = ST_FETCH;
                        pc_d    = pc_inc;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (op_done) begin
                    state_d = ST_FETCH;
                    pc_d    = pc_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        imem_addr_d = pc_d;
        busy_d      = !((state_d == ST_IDLE) || (state_d == ST_HALT) || (state_d == ST_ERR));
        halted_d    = (state_d == ST_HALT);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            imem_addr_q <= RESET_PC;
            op_valid_q  <= 1'b0;
            opcode_q    <= 4'h0;
            regaddr_q   <= 4'h0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_addr_q <= imem_addr_d;
            op_valid_q  <= op_valid_d;
            opcode_q    <= opcode_d;
            regaddr_q   <= regaddr_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
        end
    end

    assign imem_addr = imem_addr_q;
    assign op_valid  = op_valid_q;
    assign opcode    = opcode_q;
    assign regaddr   = regaddr_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tiny_seq_ctrl.sv
// Bench for tiny_seq_ctrl: directed scenarios plus random programs checked
// against an instruction-level model of the sequencer.
module tb_tiny_seq_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] imem_addr;
    logic [7:0] imem_data = 8'h00;
    logic       op_valid;
    logic [3:0] opcode;
    logic [3:0] regaddr;
    logic       op_ready;
    logic       op_done;
    logic       carry_borrow = 1'b0;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] pc;
    logic       busy;
    logic       halted;
    logic       err;

    logic [7:0] imem [256];
    logic [7:0] regs [16];
    logic [7:0] issued [$];
    logic [7:0] exp_ops [$];
    logic [3:0] dp_list [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hE};

    bit rand_mode = 1'b0;
    int ready_dly = 0;
    int done_dly  = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    tiny_seq_ctrl #(
        .STACK_DEPTH(4),
        .RESET_PC   (8'h00)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .op_valid    (op_valid),
        .opcode      (opcode),
        .regaddr     (regaddr),
        .op_ready    (op_ready),
        .op_done     (op_done),
        .carry_borrow(carry_borrow),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .err         (err)
    );

    // Synchronous program memory: address captured at an edge, data shortly after it.
    initial begin
        logic [7:0] a;
        forever begin
            @(negedge clk);
            a = imem_addr;
            @(posedge clk);
            #1;
            imem_data = imem[a];
        end
    end

    // Datapath stand-in: accepts after ready_dly cycles, commits done_dly cycles later.
    initial begin
        int r_cyc;
        int d_cyc;
        op_ready = 1'b0;
        op_done  = 1'b0;
        forever begin
            @(negedge clk);
            op_ready = 1'b0;
            op_done  = 1'b0;
            if (rstn && op_valid) begin
                r_cyc = rand_mode ? int'($urandom_range(0, 3)) : ready_dly;
                d_cyc = rand_mode ? int'($urandom_range(0, 3)) : done_dly;
                repeat (r_cyc) @(negedge clk);
                op_ready = 1'b1;
                op_done  = (d_cyc == 0);
                @(negedge clk);
                op_ready = 1'b0;
                op_done  = 1'b0;
                if (d_cyc > 0) begin
                    repeat (d_cyc - 1) @(negedge clk);
                    op_done = 1'b1;
                    @(negedge clk);
                    op_done = 1'b0;
                end
            end
        end
    end

    // Record every accepted instruction.
    initial begin
        forever begin
            @(posedge clk);
            if (rstn && op_valid && op_ready) issued.push_back({opcode, regaddr});
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_imem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) imem[i] = v;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n;
        n = 0;
        while (!(halted || err) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished"}, 32'(halted | err), 1);
    endtask

    // Instruction-level reference: executes the ISA rules directly on the program image.
    task automatic run_model(output logic [7:0] pc_o, output bit halt_o, output bit err_o,
                             output bit term_o);
        logic [7:0] p;
        logic [7:0] ins;
        logic [7:0] stk [$];
        p      = 8'h00;
        halt_o = 1'b0;
        err_o  = 1'b0;
        term_o = 1'b0;
        exp_ops.delete();
        for (int s = 0; s < 300 && !term_o; s++) begin
            ins = imem[p];
            case (ins[7:4])
                4'h8: p = carry_borrow ? regs[ins[3:0]] : p + 8'd1;
                4'hB: begin
                    if (stk.size() == 0) begin
                        err_o  = 1'b1;
                        term_o = 1'b1;
                    end else begin
                        p = stk.pop_back();
                    end
                end
                4'hC: begin
                    if (stk.size() == 4) begin
                        err_o  = 1'b1;
                        term_o = 1'b1;
                    end else begin
                        stk.push_back(p + 8'd1);
                        p = regs[ins[3:0]];
                    end
                end
                4'hD: p = regs[ins[3:0]];
                4'hF: begin
                    if (ins == 8'hFF) begin
                        halt_o = 1'b1;
                        term_o = 1'b1;
                    end else begin
                        p = p + 8'd1;
                    end
                end
                default: begin
                    exp_ops.push_back(ins);
                    p = p + 8'd1;
                end
            endcase
        end
        pc_o = p;
    endtask

    task automatic random_program();
        int r;
        for (int a = 0; a < 256; a++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3: imem[a] = {dp_list[$urandom_range(0, 10)], 4'($urandom_range(0, 15))};
                4:          imem[a] = {4'hF, 4'($urandom_range(0, 14))};
                5:          imem[a] = 8'hFF;
                6:          imem[a] = {4'h8, 4'($urandom_range(0, 15))};
                7:          imem[a] = {4'hC, 4'($urandom_range(0, 15))};
                8:          imem[a] = {4'hB, 4'($urandom_range(0, 15))};
                default:    imem[a] = {4'hD, 4'($urandom_range(0, 15))};
            endcase
        end
        for (int i = 0; i < 16; i++) regs[i] = 8'($urandom_range(0, 255));
        carry_borrow = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int         base;
        int         n;
        logic [7:0] m_pc;
        bit         m_halt, m_err, m_term;

        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        fill_imem(8'hFF);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_op_valid", 32'(op_valid), 0);
        check("rst_opcode", 32'(opcode), 0);
        check("rst_regaddr", 32'(regaddr), 0);
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_imem_addr", 32'(imem_addr), 32'h00);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_err", 32'(err), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start_busy", 32'(busy), 0);

        // Sequential program, immediate ready/done
        fill_imem(8'hFF);
        imem[0] = 8'h91;
        imem[1] = 8'h12;
        ready_dly = 0;
        done_dly  = 0;
        base = issued.size();
        pulse_start();
        check("seq_first_addr", 32'(imem_addr), 32'h00);
        check("seq_busy", 32'(busy), 1);
        repeat (7) @(posedge clk);
        #1;
        check("seq_not_halted_c7", 32'(halted), 0);
        @(posedge clk);
        #1;
        check("seq_halted_c8", 32'(halted), 1);
        check("seq_pc", 32'(pc), 32'h02);
        check("seq_n_issued", 32'(issued.size() - base), 2);
        if (issued.size() - base == 2) begin
            check("seq_op0", 32'(issued[base]), 32'h91);
            check("seq_op1", 32'(issued[base + 1]), 32'h12);
        end

        // Handshake hold: ready after 3 cycles, done 2 cycles after acceptance
        fill_imem(8'hFF);
        imem[0] = 8'h5A;
        ready_dly = 3;
        done_dly  = 2;
        pulse_start();
        n = 0;
        while (!op_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("hold_valid_%0d", i), 32'(op_valid), 1);
            check($sformatf("hold_opcode_%0d", i), 32'(opcode), 32'h5);
            check($sformatf("hold_regaddr_%0d", i), 32'(regaddr), 32'hA);
            check($sformatf("hold_pc_%0d", i), 32'(pc), 32'h00);
            @(negedge clk);
        end
        check("hold_valid_dropped", 32'(op_valid), 0);
        check("hold_pc_wait1", 32'(pc), 32'h00);
        @(negedge clk);
        check("hold_pc_wait2", 32'(pc), 32'h00);
        @(negedge clk);
        check("hold_pc_after_done", 32'(pc), 32'h01);
        wait_end("hold", 50);
        check("hold_halted", 32'(halted), 1);
        ready_dly = 0;
        done_dly  = 0;

        // Branch taken / not taken
        fill_imem(8'hFF);
        imem[0] = 8'h83;
        regs[3] = 8'h40;
        carry_borrow = 1'b1;
        pulse_start();
        wait_end("brc_taken", 50);
        check("brc_taken_pc", 32'(pc), 32'h40);
        carry_borrow = 1'b0;
        pulse_start();
        wait_end("brc_not_taken", 50);
        check("brc_not_taken_pc", 32'(pc), 32'h01);

        // Call / return
        fill_imem(8'hFF);
        regs[1] = 8'h10;
        regs[2] = 8'h30;
        imem[8'h00] = 8'hD1;
        imem[8'h10] = 8'hC2;
        imem[8'h30] = 8'hB0;
        pulse_start();
        wait_end("callret", 50);
        check("callret_pc", 32'(pc), 32'h11);
        check("callret_err", 32'(err), 0);

        // Four nested calls fill the stack exactly; RET pops the deepest return address
        fill_imem(8'hFF);
        regs[4] = 8'h50;
        imem[8'h00] = 8'hD4;
        for (int k = 0; k < 4; k++) begin
            imem[8'h50 + k] = {4'hC, 4'(5 + k)};
            regs[5 + k]     = 8'(8'h51 + k);
        end
        regs[8] = 8'h60;
        imem[8'h60] = 8'hB0;
        pulse_start();
        wait_end("depth4", 100);
        check("depth4_pc", 32'(pc), 32'h54);
        check("depth4_err", 32'(err), 0);

        // Fifth nested call overflows
        regs[8] = 8'h54;
        imem[8'h54] = 8'hC9;
        regs[9] = 8'h55;
        pulse_start();
        wait_end("overflow", 100);
        check("overflow_err", 32'(err), 1);
        check("overflow_halted", 32'(halted), 0);
        check("overflow_busy", 32'(busy), 0);
        check("overflow_pc", 32'(pc), 32'h54);

        // PC wrap through a NOP at 0xFF
        fill_imem(8'hFF);
        regs[1] = 8'hFF;
        imem[8'h00] = 8'h81;
        imem[8'hFF] = 8'hF0;
        carry_borrow = 1'b1;
        pulse_start();
        n = 0;
        while (pc != 8'hFF && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("wrap_reached_ff", 32'(pc), 32'hFF);
        carry_borrow = 1'b0;
        n = 0;
        while (pc == 8'hFF && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("wrap_pc", 32'(pc), 32'h00);
        check("wrap_imem_addr", 32'(imem_addr), 32'h00);
        wait_end("wrap", 50);
        check("wrap_final_pc", 32'(pc), 32'h01);

        // RET with an empty stack, then recovery by start
        fill_imem(8'hFF);
        imem[0] = 8'hB0;
        pulse_start();
        wait_end("underflow", 50);
        check("underflow_err", 32'(err), 1);
        check("underflow_pc", 32'(pc), 32'h00);
        pulse_start();
        check("restart_err_clear", 32'(err), 0);
        check("restart_addr", 32'(imem_addr), 32'h00);
        check("restart_busy", 32'(busy), 1);
        wait_end("underflow2", 50);
        check("underflow2_err", 32'(err), 1);

        // Asynchronous reset while an instruction is offered
        fill_imem(8'hFF);
        imem[0] = 8'h35;
        ready_dly = 5;
        pulse_start();
        n = 0;
        while (!op_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("areset_valid_before", 32'(op_valid), 1);
        #2;
        rstn = 1'b0;
        #1;
        check("areset_op_valid", 32'(op_valid), 0);
        check("areset_pc", 32'(pc), 32'h00);
        check("areset_busy", 32'(busy), 0);
        check("areset_opcode", 32'(opcode), 0);
        repeat (10) @(negedge clk);
        rstn = 1'b1;
        ready_dly = 0;
        repeat (2) @(negedge clk);
        check("areset_idle", 32'(busy), 0);

        // Random programs against the instruction-level model
        rand_mode = 1'b1;
        for (int run = 0; run < 6; run++) begin
            m_term = 1'b0;
            for (int tries = 0; tries < 20 && !m_term; tries++) begin
                random_program();
                run_model(m_pc, m_halt, m_err, m_term);
            end
            if (!m_term) begin
                imem[0] = 8'hFF;
                run_model(m_pc, m_halt, m_err, m_term);
            end
            base = issued.size();
            pulse_start();
            wait_end($sformatf("rnd%0d", run), 6000);
            check($sformatf("rnd%0d_pc", run), 32'(pc), 32'(m_pc));
            check($sformatf("rnd%0d_halted", run), 32'(halted), 32'(m_halt));
            check($sformatf("rnd%0d_err", run), 32'(err), 32'(m_err));
            check($sformatf("rnd%0d_n_ops", run), 32'(issued.size() - base), 32'(exp_ops.size()));
            for (int i = 0; i < exp_ops.size() && base + i < issued.size(); i++) begin
                check($sformatf("rnd%0d_op%0d", run, i), 32'(issued[base + i]), 32'(exp_ops[i]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tiny_seq_ctrl.md
# tiny_seq_ctrl

Instruction sequencer for the 8-bit tiny processor datapath. Fetches 8-bit instructions (opcode `[7:4]`, regaddr `[3:0]`) from a synchronous program memory and owns the PC. Resolves control-flow instructions locally (branch, jump, call, return, halt) and issues every other instruction to the datapath through a valid/ready/done handshake.

## Interface
Parameters:
- `STACK_DEPTH`, default 4: return-stack entries (1..8).
- `RESET_PC`, default 8'h00: PC loaded at reset and on `start`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: pulse; leaves IDLE/HALT/ERR and starts fetching at `RESET_PC`.
- `imem_addr` out 8: program memory address.
- `imem_data` in 8: instruction, valid one cycle after `imem_addr`.
- `op_valid` out 1: datapath instruction is valid.
- `opcode` out 4: issued opcode.
- `regaddr` out 4: issued register address.
- `op_ready` in 1: datapath accepts the instruction.
- `op_done` in 1: datapath has committed the result and `carry_borrow`.
- `carry_borrow` in 1: datapath C/B flag.
- `rd_addr` out 4: register read address for branch targets.
- `rd_data` in 8: combinational register read data.
- `pc` out 8: current PC.
- `busy` out 1: high in every state except IDLE, HALT and ERR.
- `halted` out 1: high in HALT.
- `err` out 1: sticky; set on stack overflow or underflow.

## Operation
States: IDLE, FETCH, DECODE, ISSUE, WAIT, HALT, ERR.

- **IDLE**: `start` → FETCH with `pc=RESET_PC`.
- **FETCH**: drive `imem_addr=pc`. Next state is DECODE.
- **DECODE**: latch `imem_data` into `ir`; `rd_addr=ir[3:0]` combinationally. Action depends on the opcode:
  - `0x8` BRC: if `carry_borrow` then `pc=rd_data`, else `pc=pc+1`. Next state FETCH.
  - `0xB` RET: pop the stack into `pc`. If the stack is empty → ERR. Next state FETCH.
  - `0xC` CALL: push `pc+1`, then `pc=rd_data`. If the stack is full → ERR. Next state FETCH.
  - `0xD` JMP: `pc=rd_data`. Next state FETCH.
  - `0xFF` HLT → HALT. Any other `0xF?` is a NOP: `pc+1`, FETCH.
  - All other opcodes (`0x0`–`0x7`, `0x9`, `0xA`, `0xE`) → ISSUE.
- **ISSUE**: `op_valid=1` with `opcode`/`regaddr` held stable until `op_ready`. On `op_ready`, `op_valid` drops the next cycle and the state goes to WAIT. If `op_done` coincides with `op_ready`, skip WAIT: `pc+1`, FETCH.
- **WAIT**: on `op_done`: `pc+1`, FETCH. `op_done` outside ISSUE/WAIT is ignored.
- **HALT / ERR**: outputs held. `start` → FETCH at `RESET_PC`, and the stack is cleared. `err` is cleared only by `start` or reset.

Arithmetic and boundaries:
- PC arithmetic is modulo 256: `8'hFF+1 = 8'h00`. The same applies to the pushed `pc+1`.
- A branch target is the full 8-bit `rd_data`.
- A CALL at depth `STACK_DEPTH` does not push; `err=1` and the state goes to ERR. A RET at depth 0 behaves the same way.
- BRC samples `carry_borrow` in DECODE. This is always after the `op_done` of the previous op.

## Timing
- **Reset** (async, immediate): state IDLE, `pc=RESET_PC`, `op_valid=0`, `opcode=0`, `regaddr=0`, `imem_addr=RESET_PC`, `rd_addr=0`, `busy=0`, `halted=0`, `err=0`, stack depth 0.
- **Reset mid-handshake**: `op_valid` drops asynchronously and the instruction is abandoned; the datapath is reset by the same `rstn`.
- **Latencies**:
  - Control-flow instruction: 2 cycles (FETCH, DECODE).
  - Datapath instruction: 3 cycles minimum, when `op_ready` and `op_done` arrive in the first ISSUE cycle.
  - `start` to first `imem_addr`: 1 cycle.
- All outputs are registered except `rd_addr`, which is combinational from `ir` in DECODE.

## Structure
- **Package `tiny_pkg`**:
  - Opcode localparams: `OP_BRC=4'h8`, `OP_RET=4'hB`, `OP_CALL=4'hC`, `OP_JMP=4'hD`, `OP_SYS=4'hF`; `INSN_HLT=8'hFF`.
  - Datapath opcodes `4'h0`–`4'h7`, `4'h9`, `4'hA`, `4'hE`.
  - State enum.
  - Shared with the datapath.
- **Sub-module `tiny_ret_stack`**: LIFO of `STACK_DEPTH`×8 with `push`, `pop`, `full`, `empty` and `clear`. All other logic is the FSM in `tiny_seq_ctrl`.

## Test plan
- **Sequential program**: program `0x91, 0x12, 0xFF`, `op_ready=op_done=1` immediately → issues (`9`,`1`) then (`1`,`2`); `halted=1` with `pc=0x02`; 8 cycles after `start`.
- **Handshake hold**: `op_ready` delayed 3 cycles, then `op_done` 2 cycles after acceptance → `op_valid`, `opcode` and `regaddr` stable through the delay; `pc` increments only on `op_done`.
- **Branch**: BRC `0x83` with `rd_data=0x40`, `carry_borrow=1` → `pc=0x40`. With `carry_borrow=0` → `pc` = old PC + 1.
- **Call/return**: CALL at `0x10` to `0x30`, then RET → `pc=0x11`. Five nested CALLs with `STACK_DEPTH=4` → `err=1`, state ERR, no fifth push.
- **Wrap and underflow**: NOP at `0xFF` → next fetch at `0x00`. RET with an empty stack → `err=1`. `start` → `err=0`, fetch at `RESET_PC`.
- **Async reset in ISSUE**: with `op_valid=1`, deassert `rstn` mid-cycle → `op_valid=0` before the next edge; state IDLE, `pc=RESET_PC`.
